// File: rtl/multicycle_ctrl_pkg.sv
// Shared definitions for the multi-cycle control FSM: ALU opcodes, state
// encodings, PC source select encodings and the immediate-operand decode.
package multicycle_ctrl_pkg;

  localparam int ALU_OPW = 3;

  typedef enum logic [ALU_OPW-1:0] {
    OP_ADD   = 3'b000,
    OP_ADDI  = 3'b001,
    OP_SHIFT = 3'b010,
    OP_ROT   = 3'b011,
    OP_BEQZ  = 3'b100,
    OP_SW    = 3'b101,
    OP_LW    = 3'b110,
    OP_JMP   = 3'b111
  } alu_op_e;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_e;

  localparam logic [1:0] PC_SRC_SEQ = 2'b00;  // PC + 2
  localparam logic [1:0] PC_SRC_JMP = 2'b01;  // ALU result
  localparam logic [1:0] PC_SRC_BR  = 2'b10;  // branch target adder

  // Ops whose ALU B operand is the sign-extended imm7 field.
  function automatic logic uses_imm(input logic [ALU_OPW-1:0] op);
    return (op == OP_ADDI) || (op == OP_SW) || (op == OP_LW) || (op == OP_JMP);
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Control/datapath bundle between multicycle_ctrl and the ALU, register file
// and memory. master = controller side, slave = datapath/memory side.
//   instr      : instruction register ([15:13] op, [0] shift dir)
//   mem_ready  : memory completed current request
//   alu_zero   : ALU zero flag
//   remaining signals are controller outputs (enables, selects, status)
interface multicycle_ctrl_if;
  import multicycle_ctrl_pkg::*;

  logic [15:0]        instr;
  logic               mem_ready;
  logic               alu_zero;
  logic               mem_req;
  logic               mem_we;
  logic               mem_isel;
  logic               ir_write;
  logic               pc_write;
  logic [1:0]         pc_src;
  logic [ALU_OPW-1:0] alu_opcode;
  logic               alu_shift;
  logic               alu_src_b;
  logic               reg_write;
  logic               wb_sel;
  logic               busy;
  logic               error;

  modport master (
    input  instr, mem_ready, alu_zero,
    output mem_req, mem_we, mem_isel, ir_write, pc_write, pc_src,
           alu_opcode, alu_shift, alu_src_b, reg_write, wb_sel, busy, error
  );

  modport slave (
    output instr, mem_ready, alu_zero,
    input  mem_req, mem_we, mem_isel, ir_write, pc_write, pc_src,
           alu_opcode, alu_shift, alu_src_b, reg_write, wb_sel, busy, error
  );

endinterface

// File: rtl/multicycle_ctrl_mem_timeout_cnt.sv
// Memory wait-state counter.
//   clk, rst_n : clock, async active-low reset
//   clr        : return count to zero (no request pending, or request done)
//   en         : one more cycle spent waiting on mem_ready
//   tc         : this waiting cycle brings the count to MAX
module multicycle_ctrl_mem_timeout_cnt #(
  parameter int MAX = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [3:0] cnt_q;

  assign tc = en && (cnt_q == 4'(MAX - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   cnt_q <= '0;
    else if (clr) cnt_q <= '0;
    else if (en)  cnt_q <= cnt_q + 4'd1;
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM in front of the 16-bit ALU and register file.
//   clk, rst_n : clock, async active-low reset
//   bus        : multicycle_ctrl_if.master (instr/mem_ready/alu_zero in,
//                memory handshake, PC/IR/ALU/regfile controls and status out)
//
// state  | meaning
// FETCH  | instruction fetch request (idle after reset until first clk)
// DECODE | latch op and shift direction from instr
// EXEC   | drive ALU; resolve BEQZ/JMP, pick MEM or WB
// MEM    | data load/store request, ALU address held
// WB     | register file write, one cycle
// HALT   | memory timeout, left only by reset
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int OPW         = ALU_OPW
) (
  input  logic             clk,
  input  logic             rst_n,
  multicycle_ctrl_if.master bus
);

  logic [2:0]     state_q, state_d;
  logic           started_q;
  logic           error_q;
  logic [OPW-1:0] op_q;
  logic           shift_q;
  logic           req;
  logic           mem_done;
  logic           tmo_tc;
  logic           alu_stage;

  // started_q keeps the reset FETCH quiet until the first clock edge.
  assign req       = started_q && ((state_q == ST_FETCH) || (state_q == ST_MEM));
  assign mem_done  = req && bus.mem_ready;
  assign alu_stage = (state_q == ST_EXEC) || (state_q == ST_MEM) || (state_q == ST_WB);

  multicycle_ctrl_mem_timeout_cnt #(.MAX(MEM_TIMEOUT)) u_tmo (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (!req || bus.mem_ready),
    .en    (req && !bus.mem_ready),
    .tc    (tmo_tc)
  );

  always_comb begin
    state_d = state_q;
    if (tmo_tc) begin
      state_d = ST_HALT;
    end else begin
      case (state_q)
        ST_FETCH:  if (mem_done) state_d = ST_DECODE;
        ST_DECODE: state_d = ST_EXEC;
        ST_EXEC: begin
          case (op_q)
            OP_BEQZ, OP_JMP: state_d = ST_FETCH;
            OP_SW, OP_LW:    state_d = ST_MEM;
            default:         state_d = ST_WB;
          endcase
        end
        ST_MEM:    if (mem_done) state_d = (op_q == OP_LW) ? ST_WB : ST_FETCH;
        ST_WB:     state_d = ST_FETCH;
        default:   state_d = ST_HALT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_FETCH;
      started_q <= 1'b0;
      error_q   <= 1'b0;
      op_q      <= '0;
      shift_q   <= 1'b0;
    end else if (!started_q) begin
      started_q <= 1'b1;
    end else begin
      state_q <= state_d;
      if (tmo_tc) error_q <= 1'b1;
      // Latched so later instr changes cannot disturb EXEC/MEM/WB.
      if (state_q == ST_DECODE) begin
        op_q    <= bus.instr[15:13];
        shift_q <= bus.instr[0];
      end
    end
  end

  always_comb begin
    bus.mem_req    = req;
    bus.mem_isel   = req && (state_q == ST_FETCH);
    bus.mem_we     = req && (state_q == ST_MEM) && (op_q == OP_SW);
    bus.ir_write   = mem_done && (state_q == ST_FETCH);
    bus.pc_write   = mem_done && (state_q == ST_FETCH);
    bus.pc_src     = PC_SRC_SEQ;
    if (state_q == ST_EXEC) begin
      if (op_q == OP_JMP) begin
        bus.pc_write = 1'b1;
        bus.pc_src   = PC_SRC_JMP;
      end else if ((op_q == OP_BEQZ) && bus.alu_zero) begin
        bus.pc_write = 1'b1;
        bus.pc_src   = PC_SRC_BR;
      end
    end
    // ALU controls held from EXEC through MEM/WB so the result stays valid.
    bus.alu_opcode = alu_stage ? op_q : '0;
    bus.alu_shift  = alu_stage && shift_q;
    bus.alu_src_b  = alu_stage && uses_imm(op_q);
    bus.reg_write  = (state_q == ST_WB);
    bus.wb_sel     = (state_q == ST_WB) && (op_q == OP_LW);
    bus.busy       = started_q;
    bus.error      = error_q;
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
module tb_multicycle_ctrl;
  import multicycle_ctrl_pkg::*;

  localparam int TMO = 15;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       mem_isel;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_src;
    logic [2:0] alu_opcode;
    logic       alu_shift;
    logic       alu_src_b;
    logic       reg_write;
    logic       wb_sel;
    logic       busy;
    logic       error;
  } out_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;
  logic err_exp = 1'b0;

  always #5 clk = ~clk;

  multicycle_ctrl_if bus();

  multicycle_ctrl #(.MEM_TIMEOUT(TMO), .OPW(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  function automatic logic rb();
    return 1'($urandom);
  endfunction

  function automatic out_t obs();
    out_t o;
    o = {bus.mem_req, bus.mem_we, bus.mem_isel, bus.ir_write, bus.pc_write,
         bus.pc_src, bus.alu_opcode, bus.alu_shift, bus.alu_src_b,
         bus.reg_write, bus.wb_sel, bus.busy, bus.error};
    return o;
  endfunction

  task automatic chk(input string tag, input out_t e);
    out_t o;
    o = obs();
    tests++;
    assert (o === e) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  // Drive one cycle of inputs, sample on the falling edge, end just after
  // the next rising edge.
  task automatic step(input string tag, input out_t e, input logic rdy,
                      input logic zero, input logic [15:0] ins);
    bus.mem_ready = rdy;
    bus.alu_zero  = zero;
    bus.instr     = ins;
    @(negedge clk);
    chk(tag, e);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n         = 1'b0;
    err_exp       = 1'b0;
    bus.mem_ready = 1'b1;
    bus.alu_zero  = 1'b0;
    bus.instr     = '0;
    @(posedge clk);
    #1;
    chk("reset", '0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("idle_after_reset", '0);
    @(posedge clk);
    #1;
  endtask

  // Expected per-cycle trace of one instruction, built from the
  // instruction-level rules: fetch (with fw wait cycles), decode, execute,
  // optional memory phase (mw wait cycles), optional writeback.
  // abort: stop after mw memory wait cycles, leaving the access pending.
  task automatic run_instr(input logic [15:0] ins, input int fw, input int mw,
                           input logic zero, input logic abort);
    logic [2:0] op;
    out_t       e;
    out_t       alu;
    int         nw;
    op = ins[15:13];

    e = '0;  e.busy = 1'b1;  e.error = err_exp;
    e.mem_req = 1'b1;  e.mem_isel = 1'b1;
    for (int i = 0; i < fw; i++) step("fetch_wait", e, 1'b0, rb(), ins);
    e.ir_write = 1'b1;  e.pc_write = 1'b1;
    step("fetch_done", e, 1'b1, rb(), ins);

    e = '0;  e.busy = 1'b1;
    step("decode", e, rb(), rb(), ins);

    alu = '0;
    alu.busy       = 1'b1;
    alu.alu_opcode = op;
    alu.alu_shift  = ins[0];
    alu.alu_src_b  = (op == 3'd1) || (op == 3'd5) || (op == 3'd6) || (op == 3'd7);
    e = alu;
    if (op == 3'd7) begin
      e.pc_write = 1'b1;  e.pc_src = 2'b01;
    end else if (op == 3'd4 && zero) begin
      e.pc_write = 1'b1;  e.pc_src = 2'b10;
    end
    step("exec", e, rb(), zero, 16'($urandom));

    if (op == 3'd5 || op == 3'd6) begin
      e = alu;
      e.mem_req = 1'b1;
      e.mem_we  = (op == 3'd5);
      nw = (mw < TMO) ? mw : TMO;
      for (int i = 0; i < nw; i++) step("mem_wait", e, 1'b0, rb(), 16'($urandom));
      if (abort || mw >= TMO) return;
      step("mem_done", e, 1'b1, rb(), 16'($urandom));
    end

    if (op <= 3'd3 || op == 3'd6) begin
      e = alu;
      e.reg_write = 1'b1;
      e.wb_sel    = (op == 3'd6);
      step("wb", e, rb(), rb(), 16'($urandom));
    end
  endtask

  initial begin
    out_t h;
    bus.instr     = '0;
    bus.mem_ready = 1'b0;
    bus.alu_zero  = 1'b0;

    do_reset();

    run_instr(16'h0000, 0, 0, 1'b0, 1'b0);   // ADD
    run_instr(16'h4001, 0, 0, 1'b1, 1'b0);   // SHIFT right
    run_instr(16'h8000, 0, 0, 1'b1, 1'b0);   // BEQZ taken
    run_instr(16'h8000, 0, 0, 1'b0, 1'b0);   // BEQZ not taken
    run_instr(16'hE000, 1, 0, 1'b0, 1'b0);   // JMP
    run_instr(16'h2000, 0, 0, 1'b0, 1'b0);   // ADDI
    run_instr(16'h6001, 2, 0, 1'b1, 1'b0);   // ROT
    run_instr(16'hC000, 0, 3, 1'b0, 1'b0);   // LW with memory wait
    run_instr(16'hA000, 0, 0, 1'b0, 1'b0);   // SW
    run_instr(16'hA000, 14, 14, 1'b0, 1'b0); // longest waits without timeout

    for (int n = 0; n < 40; n++) begin
      run_instr(16'($urandom), int'($urandom_range(0, 4)),
                (n % 10 == 9) ? 14 : int'($urandom_range(0, 4)), rb(), 1'b0);
    end

    // Async reset while a load is waiting in MEM.
    run_instr(16'hC000, 0, 2, 1'b0, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_mid_mem", '0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("idle_after_async_reset", '0);
    @(posedge clk);
    #1;
    run_instr(16'h0000, 0, 0, 1'b0, 1'b0);

    // Store that never completes: timeout into HALT.
    run_instr(16'hA000, 0, TMO, 1'b0, 1'b0);
    err_exp = 1'b1;
    h = '0;  h.busy = 1'b1;  h.error = 1'b1;
    for (int i = 0; i < 5; i++) step("halt", h, rb(), rb(), 16'($urandom));

    do_reset();
    run_instr(16'h4000, 0, 0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
